// File: rtl/npc_mem_pkg.sv
// rtl/npc_mem_pkg.sv - shared FSM states and store-mask constants for the DPI memory arbiter
package npc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_RESP  = 2'd1,
    ST_LSU_RESP = 2'd2
  } state_t;

  localparam logic [7:0] MASK_BYTE  = 8'h01;
  localparam logic [7:0] MASK_HALF  = 8'h03;
  localparam logic [7:0] MASK_WORD  = 8'h0F;
  localparam logic [7:0] MASK_DWORD = 8'hFF;

  // Only naturally sized, low-aligned masks are accepted for stores
  function automatic logic mask_legal(input logic [7:0] mask);
    return (mask == MASK_BYTE) || (mask == MASK_HALF) ||
           (mask == MASK_WORD) || (mask == MASK_DWORD);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant pointer
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic req_if,
  input  logic req_lsu,
  input  logic accept,
  output logic grant_if,
  output logic grant_lsu
);

  // 1 = LSU was granted last, so IF wins the next tie
  logic last_lsu;

  // Grant the sole requester, or on a tie the one not granted last
  always_comb begin
    grant_if  = req_if & (~req_lsu | last_lsu);
    grant_lsu = req_lsu & ~grant_if;
  end

  // Pointer resets to LSU and follows every accepted grant
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_lsu <= 1'b1;
    end else if (accept) begin
      last_lsu <= grant_lsu;
    end
  end

endmodule

// File: rtl/dpic_mem_arbiter.sv
// rtl/dpic_mem_arbiter.sv - arbitrates fetch and load/store requests onto a single DPI memory port
module dpic_mem_arbiter
  import npc_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [63:0] if_resp_data,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [63:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [63:0] lsu_resp_data,
  output logic        lsu_resp_err,
  output logic        mem_rd_en,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rd_data,
  output logic        mem_we_en,
  output logic [63:0] mem_we_data,
  output logic [7:0]  mem_we_mask
);

  state_t      state;
  state_t      state_next;
  logic        idle_ok;
  logic        grant_if;
  logic        grant_lsu;
  logic        accept;
  logic        store_legal;
  logic [63:0] resp_data;
  logic        resp_err;

  // Requests are only visible to the arbiter in IDLE and out of reset
  assign idle_ok     = (state == ST_IDLE) && reset;
  assign accept      = grant_if | grant_lsu;
  assign store_legal = mask_legal(lsu_req_wmask);

  rr_arb2 u_rr_arb2 (
    .clock     (clock),
    .reset     (reset),
    .req_if    (if_req_valid & idle_ok),
    .req_lsu   (lsu_req_valid & idle_ok),
    .accept    (accept),
    .grant_if  (grant_if),
    .grant_lsu (grant_lsu)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, readies and memory strobes; strobes only in the accept cycle
  always_comb begin
    state_next    = state;
    if_req_ready  = 1'b0;
    lsu_req_ready = 1'b0;
    mem_rd_en     = 1'b0;
    mem_addr      = 64'd0;
    mem_we_en     = 1'b0;
    mem_we_data   = 64'd0;
    mem_we_mask   = 8'd0;
    case (state)
      ST_IDLE: begin
        if_req_ready  = grant_if;
        lsu_req_ready = grant_lsu;
        if (grant_if) begin
          mem_rd_en  = 1'b1;
          mem_addr   = if_req_addr;
          state_next = ST_IF_RESP;
        end else if (grant_lsu) begin
          mem_addr   = lsu_req_addr;
          state_next = ST_LSU_RESP;
          if (!lsu_req_wen) begin
            mem_rd_en = 1'b1;
          end else if (store_legal) begin
            mem_we_en   = 1'b1;
            mem_we_data = lsu_req_wdata;
            mem_we_mask = lsu_req_wmask;
          end
        end
      end
      ST_IF_RESP: begin
        if (if_resp_ready) state_next = ST_IDLE;
      end
      ST_LSU_RESP: begin
        if (lsu_resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture read data (or store status) at the end of the accept cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      resp_data <= 64'd0;
      resp_err  <= 1'b0;
    end else if (grant_if) begin
      resp_data <= mem_rd_data;
      resp_err  <= 1'b0;
    end else if (grant_lsu) begin
      resp_data <= lsu_req_wen ? 64'd0 : mem_rd_data;
      resp_err  <= lsu_req_wen & ~store_legal;
    end else if (state != ST_IDLE && state_next == ST_IDLE) begin
      resp_data <= 64'd0;
      resp_err  <= 1'b0;
    end
  end

  assign if_resp_valid  = (state == ST_IF_RESP);
  assign if_resp_data   = if_resp_valid ? resp_data : 64'd0;
  assign lsu_resp_valid = (state == ST_LSU_RESP);
  assign lsu_resp_data  = lsu_resp_valid ? resp_data : 64'd0;
  assign lsu_resp_err   = lsu_resp_valid & resp_err;

endmodule

// File: tb/tb_dpic_mem_arbiter.sv
// tb/tb_dpic_mem_arbiter.sv - directed self-checking bench for dpic_mem_arbiter
module tb_dpic_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic        if_resp_ready;
  logic [63:0] if_resp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [63:0] lsu_resp_data;
  logic        lsu_resp_err;
  logic        mem_rd_en;
  logic [63:0] mem_addr;
  logic [63:0] mem_rd_data;
  logic        mem_we_en;
  logic [63:0] mem_we_data;
  logic [7:0]  mem_we_mask;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  dpic_mem_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_ready  (if_resp_ready),
    .if_resp_data   (if_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_resp_data  (lsu_resp_data),
    .lsu_resp_err   (lsu_resp_err),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .mem_we_en      (mem_we_en),
    .mem_we_data    (mem_we_data),
    .mem_we_mask    (mem_we_mask)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [63:0] vals [4];
  logic [63:0] held;

  initial begin
    vals[0] = 64'h0000_0000_AAAA_0001;
    vals[1] = 64'h0000_0000_BBBB_0002;
    vals[2] = 64'h0000_0000_CCCC_0003;
    vals[3] = 64'h0000_0000_DDDD_0004;

    reset          = 1'b0;
    if_req_valid   = 1'b1;
    if_req_addr    = 64'h8000_0000;
    if_resp_ready  = 1'b1;
    lsu_req_valid  = 1'b1;
    lsu_req_addr   = 64'h8000_0100;
    lsu_req_wen    = 1'b1;
    lsu_req_wdata  = 64'h55;
    lsu_req_wmask  = 8'hFF;
    lsu_resp_ready = 1'b1;
    mem_rd_data    = 64'd0;

    // Reset state with requests pending: no strobes, no readies
    step();
    step();
    @(negedge clock);
    check("rst_if_resp_valid", {63'd0, if_resp_valid}, 64'd0);
    check("rst_lsu_resp_valid", {63'd0, lsu_resp_valid}, 64'd0);
    check("rst_lsu_resp_err", {63'd0, lsu_resp_err}, 64'd0);
    check("rst_if_resp_data", if_resp_data, 64'd0);
    check("rst_lsu_resp_data", lsu_resp_data, 64'd0);
    check("rst_readies", {62'd0, if_req_ready, lsu_req_ready}, 64'd0);
    check("rst_strobes", {62'd0, mem_rd_en, mem_we_en}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);

    // IF-only read, one-cycle latency
    step();
    reset         = 1'b1;
    lsu_req_valid = 1'b0;
    mem_rd_data   = 64'h1122_3344_5566_7788;
    @(negedge clock);
    check("if_rd_ready", {63'd0, if_req_ready}, 64'd1);
    check("if_rd_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
    check("if_rd_en_T", {63'd0, mem_rd_en}, 64'd1);
    check("if_rd_addr", mem_addr, 64'h8000_0000);
    step();
    if_req_valid = 1'b0;
    @(negedge clock);
    check("if_rd_valid_T1", {63'd0, if_resp_valid}, 64'd1);
    check("if_rd_data_T1", if_resp_data, 64'h1122_3344_5566_7788);
    check("if_rd_en_T1", {63'd0, mem_rd_en}, 64'd0);
    check("if_rd_addr_T1", mem_addr, 64'd0);
    step();
    @(negedge clock);
    check("if_rd_back_idle", {63'd0, if_resp_valid}, 64'd0);

    // Round-robin after reset: IF, LSU, IF, LSU (load with an illegal mask, ignored)
    step();
    reset = 1'b0;
    step();
    reset         = 1'b1;
    if_req_valid  = 1'b1;
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_wmask = 8'h05;
    for (int i = 0; i < 4; i++) begin
      mem_rd_data = vals[i];
      @(negedge clock);
      check($sformatf("rr%0d_if_ready", i), {63'd0, if_req_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_lsu_ready", i), {63'd0, lsu_req_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
      step();
      @(negedge clock);
      if (i % 2 == 0) begin
        check($sformatf("rr%0d_if_data", i), if_resp_data, vals[i]);
        check($sformatf("rr%0d_if_valid", i), {63'd0, if_resp_valid}, 64'd1);
      end else begin
        check($sformatf("rr%0d_lsu_data", i), lsu_resp_data, vals[i]);
        check($sformatf("rr%0d_lsu_err", i), {63'd0, lsu_resp_err}, 64'd0);
      end
      check($sformatf("rr%0d_resp_readies", i), {62'd0, if_req_ready, lsu_req_ready}, 64'd0);
      step();
    end
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;

    // Legal byte store
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b1;
    lsu_req_addr  = 64'h8000_0010;
    lsu_req_wdata = 64'hAB;
    lsu_req_wmask = 8'h01;
    mem_rd_data   = 64'hDEAD_BEEF;
    @(negedge clock);
    check("st_we_en", {63'd0, mem_we_en}, 64'd1);
    check("st_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check("st_addr", mem_addr, 64'h8000_0010);
    check("st_data", mem_we_data, 64'hAB);
    check("st_mask", {56'd0, mem_we_mask}, 64'h01);
    step();
    lsu_req_valid = 1'b0;
    @(negedge clock);
    check("st_we_en_T1", {63'd0, mem_we_en}, 64'd0);
    check("st_resp_valid", {63'd0, lsu_resp_valid}, 64'd1);
    check("st_resp_err", {63'd0, lsu_resp_err}, 64'd0);
    check("st_resp_data", lsu_resp_data, 64'd0);
    step();

    // Illegal store mask
    lsu_req_valid = 1'b1;
    lsu_req_wmask = 8'h05;
    @(negedge clock);
    check("bad_ready", {63'd0, lsu_req_ready}, 64'd1);
    check("bad_we_en", {63'd0, mem_we_en}, 64'd0);
    check("bad_we_mask", {56'd0, mem_we_mask}, 64'd0);
    step();
    lsu_req_valid = 1'b0;
    @(negedge clock);
    check("bad_resp_valid", {63'd0, lsu_resp_valid}, 64'd1);
    check("bad_resp_err", {63'd0, lsu_resp_err}, 64'd1);
    check("bad_resp_data", lsu_resp_data, 64'd0);
    step();

    // IF response back-pressure for 5 cycles with LSU waiting
    if_req_valid  = 1'b1;
    if_req_addr   = 64'h8000_0040;
    if_resp_ready = 1'b0;
    mem_rd_data   = 64'h0F0E_0D0C_0B0A_0908;
    held          = 64'h0F0E_0D0C_0B0A_0908;
    step();
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = 64'h8000_0080;
    mem_rd_data   = 64'h7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("stall%0d_valid", i), {63'd0, if_resp_valid}, 64'd1);
      check($sformatf("stall%0d_data", i), if_resp_data, held);
      check($sformatf("stall%0d_readies", i), {62'd0, if_req_ready, lsu_req_ready}, 64'd0);
      step();
    end
    if_resp_ready = 1'b1;
    @(negedge clock);
    check("hs_no_accept", {62'd0, lsu_req_ready, mem_rd_en}, 64'd0);
    step();
    lsu_resp_ready = 1'b0;
    @(negedge clock);
    check("post_hs_lsu_ready", {63'd0, lsu_req_ready}, 64'd1);
    step();
    lsu_req_valid = 1'b0;
    @(negedge clock);
    check("pend_lsu_valid", {63'd0, lsu_resp_valid}, 64'd1);
    check("pend_lsu_data", lsu_resp_data, 64'h7777);

    // Reset while a LSU response is pending
    step();
    reset         = 1'b0;
    if_req_valid  = 1'b1;
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b1;
    lsu_req_wmask = 8'hFF;
    @(negedge clock);
    check("rst2_strobes", {62'd0, mem_rd_en, mem_we_en}, 64'd0);
    check("rst2_readies", {62'd0, if_req_ready, lsu_req_ready}, 64'd0);
    step();
    reset = 1'b1;
    @(negedge clock);
    check("rst2_lsu_valid", {63'd0, lsu_resp_valid}, 64'd0);
    check("rst2_lsu_data", lsu_resp_data, 64'd0);
    check("rst2_tie_if", {62'd0, if_req_ready, lsu_req_ready}, 64'd2);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dpic_mem_arbiter.md
DPIC_MEM_ARBITER -- requirements
Module: dpic_mem_arbiter

Interface
REQ-001 SHALL have no parameters; all address and data widths are fixed at 64 bits and the mask at 8 bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port if_req_valid  input  1  fetch read request valid.
REQ-005 SHALL have port if_req_ready  output  1  fetch request accepted this cycle when high with valid.
REQ-006 SHALL have port if_req_addr  input  64  fetch read address.
REQ-007 SHALL have port if_resp_valid  output  1  fetch read data valid.
REQ-008 SHALL have port if_resp_ready  input  1  fetch consumer ready.
REQ-009 SHALL have port if_resp_data  output  64  fetch read data.
REQ-010 SHALL have port lsu_req_valid  input  1  load/store request valid.
REQ-011 SHALL have port lsu_req_ready  output  1  load/store request accepted this cycle when high with valid.
REQ-012 SHALL have port lsu_req_addr  input  64  load/store address.
REQ-013 SHALL have port lsu_req_wen  input  1  1 = store, 0 = load.
REQ-014 SHALL have port lsu_req_wdata  input  64  store data.
REQ-015 SHALL have port lsu_req_wmask  input  8  store byte mask; legal values are 8'h01, 8'h03, 8'h0F and 8'hFF.
REQ-016 SHALL have port lsu_resp_valid  output  1  load data or store completion valid.
REQ-017 SHALL have port lsu_resp_ready  input  1  load/store consumer ready.
REQ-018 SHALL have port lsu_resp_data  output  64  load data; 0 for stores.
REQ-019 SHALL have port lsu_resp_err  output  1  store carried an illegal mask.
REQ-020 SHALL have port mem_rd_en  output  1  to the DPI memory read enable.
REQ-021 SHALL have port mem_addr  output  64  shared read/write address to the DPI memory.
REQ-022 SHALL have port mem_rd_data  input  64  combinational read data from the DPI memory.
REQ-023 SHALL have port mem_we_en  output  1  DPI memory write enable.
REQ-024 SHALL have port mem_we_data  output  64  DPI memory write data.
REQ-025 SHALL have port mem_we_mask  output  8  DPI memory write mask.

Function
REQ-026 SHALL implement the FSM states IDLE, IF_RESP and LSU_RESP, with reset state IDLE.
REQ-027 SHALL assert a req_ready only in IDLE, and only for the single granted requester; both readies are low in the RESP states.
REQ-028 SHALL arbitrate round-robin when both requesters are valid in IDLE: the grant goes to the requester not granted last, and the last-grant pointer updates on every accept.
REQ-029 SHALL make the IF requester win the first tie after reset (the last-grant pointer resets to LSU).
REQ-030 SHALL, in the accept cycle T and only in T, drive mem_addr to the granted address, assert mem_rd_en for reads, and assert mem_we_en for legal-mask stores.
REQ-031 SHALL register mem_rd_data at the end of T, so that resp_valid rises at T+1 (one-cycle latency).
REQ-032 SHALL hold resp_valid and the response data stable until resp_ready is seen high, then return to IDLE on the next edge; no new accept occurs in that same cycle, giving at most one transaction per 2 cycles.
REQ-033 SHALL, for an illegal store mask, keep mem_we_en low, return lsu_resp_err=1 with lsu_resp_data=0, and otherwise hold lsu_resp_err at 0.
REQ-034 SHALL drive mem_rd_en=0, mem_we_en=0, and mem_addr, mem_we_data and mem_we_mask all 0 in every non-accept cycle.
REQ-035 SHALL ignore the lsu_req_wmask value on loads.

Reset
REQ-036 SHALL, when reset is low at a clock edge, enter IDLE with all resp_valid, resp_data and lsu_resp_err outputs at 0 and the last-grant pointer at LSU.
REQ-037 SHALL, on reset during IF_RESP or LSU_RESP, discard the pending response with no replay, and SHALL suppress all memory strobes while reset is low.

Structure
REQ-038 SHALL place the FSM state enum and the legal-mask constants in the shared package npc_mem_pkg.
REQ-039 SHALL contain one sub-module, rr_arb2 (a 2-way round-robin grant with pointer), with the DPI memory instantiated outside this block.

Verification
REQ-040 SHALL cover this case: IF-only read at 0x8000_0000 with memory returning 0x1122334455667788 -> if_resp_valid at T+1 with that data, and mem_rd_en high for exactly 1 cycle.
REQ-041 SHALL cover this case: both requesters valid for 4 transactions after reset -> grant order IF, LSU, IF, LSU.
REQ-042 SHALL cover this case: LSU store to addr 0x8000_0010 with data 0xAB and mask 0x01 -> mem_we_en for 1 cycle with mask 0x01, then lsu_resp_valid with err=0 and data=0.
REQ-043 SHALL cover this case: LSU store with mask 0x05 -> no mem_we_en, and lsu_resp_err=1.
REQ-044 SHALL cover this case: if_resp_ready held low for 5 cycles -> if_resp_data stable and both req_ready low throughout.
REQ-045 SHALL cover this case: reset asserted during LSU_RESP -> resp_valid 0 at the next edge, state IDLE, and the first tie afterwards granted to IF.
